// File: rtl/line_sequencer.sv
// line_sequencer: plays the piecewise-linear segment program from the register group.
// Optional fractional segment duration: define SEQ_FRAC_EN.
`default_nettype none

module line_sequencer #(
   parameter int DATA_SIZE = 32,
   parameter int NSEG      = 9,
   parameter int IDX_W     = 4
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic                      start,
   input  logic                      stop,
   input  logic [NSEG*DATA_SIZE-1:0] linea,
   input  logic [NSEG*DATA_SIZE-1:0] linet,
   input  logic [NSEG*DATA_SIZE-1:0] linet_f,
   input  logic [NSEG*DATA_SIZE-1:0] offset,
   input  logic [DATA_SIZE-1:0]      linenmb,
   input  logic [DATA_SIZE-1:0]      repeatcycle,
   output logic                      busy,
   output logic                      seg_valid,
   output logic                      seg_strobe,
   output logic [IDX_W-1:0]          seg_idx,
   output logic [DATA_SIZE-1:0]      seg_amp,
   output logic [DATA_SIZE-1:0]      seg_offset,
   output logic [DATA_SIZE-1:0]      pass_cnt,
   output logic                      done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [IDX_W:0]       n_seg;
   logic [DATA_SIZE-1:0] rep;
   logic [DATA_SIZE-1:0] cnt;

   logic                 accept;
   logic                 enter;
   logic [IDX_W-1:0]     enter_idx;
   logic                 done_nxt;
   logic                 pass_inc;
   logic                 last_seg;
   logic [DATA_SIZE-1:0] pass_next;
   logic [IDX_W:0]       n_clamp;
   logic [DATA_SIZE-1:0] ent_t;
   logic [DATA_SIZE-1:0] base_m1;
   logic [DATA_SIZE-1:0] cnt_load;
   logic                 carry;

   logic [DATA_SIZE-1:0] slot_a [NSEG];
   logic [DATA_SIZE-1:0] slot_t [NSEG];
   logic [DATA_SIZE-1:0] slot_o [NSEG];

   generate
      for (genvar g = 0; g < NSEG; g++) begin : g_slot
         assign slot_a[g] = linea[g*DATA_SIZE +: DATA_SIZE];
         assign slot_t[g] = linet[g*DATA_SIZE +: DATA_SIZE];
         assign slot_o[g] = offset[g*DATA_SIZE +: DATA_SIZE];
      end
   endgenerate

`ifdef SEQ_FRAC_EN
   logic [DATA_SIZE-1:0] slot_f [NSEG];
   logic [DATA_SIZE-1:0] frac_acc;
   logic [DATA_SIZE:0]   frac_sum;

   generate
      for (genvar g = 0; g < NSEG; g++) begin : g_frac_slot
         assign slot_f[g] = linet_f[g*DATA_SIZE +: DATA_SIZE];
      end
   endgenerate

   assign frac_sum = {1'b0, frac_acc} + {1'b0, slot_f[enter_idx]};
   assign carry    = frac_sum[DATA_SIZE];

   // Accumulator persists across passes so the fractional remainder keeps averaging out.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         frac_acc <= '0;
      end else if (accept) begin
         frac_acc <= '0;
      end else if (enter) begin
         frac_acc <= frac_sum[DATA_SIZE-1:0];
      end
   end
`else
   logic unused_frac;
   assign unused_frac = ^linet_f;
   assign carry       = 1'b0;
`endif

   assign n_clamp   = (linenmb > DATA_SIZE'(NSEG)) ? (IDX_W+1)'(NSEG) : linenmb[IDX_W:0];
   assign last_seg  = (({1'b0, seg_idx} + (IDX_W+1)'(1)) == n_seg);
   assign pass_next = pass_cnt + DATA_SIZE'(1);

   // A zero duration still plays one cycle; the fractional carry adds one more.
   assign ent_t    = slot_t[enter_idx];
   assign base_m1  = (ent_t == '0) ? '0 : ent_t - DATA_SIZE'(1);
   assign cnt_load = base_m1 + {{(DATA_SIZE-1){1'b0}}, carry};

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      enter     = 1'b0;
      enter_idx = '0;
      done_nxt  = 1'b0;
      pass_inc  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !stop) begin
               accept    = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (stop || (n_seg == '0)) begin
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               enter     = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop) begin
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (cnt == '0) begin
               if (!last_seg) begin
                  enter     = 1'b1;
                  enter_idx = seg_idx + IDX_W'(1);
               end else begin
                  pass_inc = 1'b1;
                  if ((rep != '0) && (pass_next == rep)) begin
                     done_nxt  = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     enter = 1'b1;
                  end
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         n_seg      <= '0;
         rep        <= '0;
         cnt        <= '0;
         pass_cnt   <= '0;
         seg_idx    <= '0;
         seg_amp    <= '0;
         seg_offset <= '0;
         seg_strobe <= 1'b0;
         done       <= 1'b0;
      end else begin
         seg_strobe <= enter;
         done       <= done_nxt;
         if (accept) begin
            n_seg    <= n_clamp;
            rep      <= repeatcycle;
            pass_cnt <= '0;
         end else if (pass_inc) begin
            pass_cnt <= pass_next;
         end
         // Slot registers are sampled only here, so live writes land at the next entry.
         if (enter) begin
            seg_idx    <= enter_idx;
            seg_amp    <= slot_a[enter_idx];
            seg_offset <= slot_o[enter_idx];
            cnt        <= cnt_load;
         end else if ((state == ST_RUN) && (cnt != '0)) begin
            cnt <= cnt - DATA_SIZE'(1);
         end
      end
   end

   assign busy      = (state != ST_IDLE);
   assign seg_valid = (state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_line_sequencer.sv
// tb_line_sequencer: randomized and directed checks of line_sequencer against a trace model.
`default_nettype none

module tb_line_sequencer;

   localparam int DS   = 32;
   localparam int NSEG = 9;
   localparam int IW   = 4;

   logic            aclk = 1'b0;
   logic            areset;
   logic            start;
   logic            stop;
   logic [NSEG*DS-1:0] linea, linet, linet_f, offset;
   logic [DS-1:0]   linenmb, repeatcycle;
   logic            busy, seg_valid, seg_strobe, done;
   logic [IW-1:0]   seg_idx;
   logic [DS-1:0]   seg_amp, seg_offset, pass_cnt;

   logic [DS-1:0]   la [NSEG];
   logic [DS-1:0]   lt [NSEG];
   logic [DS-1:0]   lf [NSEG];
   logic [DS-1:0]   lo [NSEG];
   int              nlin;
   int              rep;

   int              n_checks = 0;
   int              n_fail   = 0;

   typedef struct {
      bit          valid;
      bit          strobe;
      bit          busy;
      bit          done;
      int          idx;
      logic [DS-1:0] amp;
      logic [DS-1:0] off;
   } exp_t;

   exp_t q[$];
   int   exp_pass;

   always #5 aclk = ~aclk;

   always_comb begin
      for (int i = 0; i < NSEG; i++) begin
         linea[i*DS +: DS]   = la[i];
         linet[i*DS +: DS]   = lt[i];
         linet_f[i*DS +: DS] = lf[i];
         offset[i*DS +: DS]  = lo[i];
      end
   end

   assign linenmb     = DS'(nlin);
   assign repeatcycle = DS'(rep);

   line_sequencer #(.DATA_SIZE(DS), .NSEG(NSEG), .IDX_W(IW)) dut (
      .aclk(aclk), .areset(areset), .start(start), .stop(stop),
      .linea(linea), .linet(linet), .linet_f(linet_f), .offset(offset),
      .linenmb(linenmb), .repeatcycle(repeatcycle),
      .busy(busy), .seg_valid(seg_valid), .seg_strobe(seg_strobe),
      .seg_idx(seg_idx), .seg_amp(seg_amp), .seg_offset(seg_offset),
      .pass_cnt(pass_cnt), .done(done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Cycle-by-cycle expectation of one program, starting at the cycle after start.
   task automatic build_model();
      int n, d;
      bit carry;
      logic [DS:0] acc;
      exp_t e;
      q.delete();
      n   = (nlin > NSEG) ? NSEG : nlin;
      acc = '0;
      e = '{valid: 0, strobe: 0, busy: 1, done: 0, idx: 0, amp: '0, off: '0};
      q.push_back(e);
      if (n > 0) begin
         for (int p = 0; p < rep; p++) begin
            for (int i = 0; i < n; i++) begin
               carry = 1'b0;
`ifdef SEQ_FRAC_EN
               acc   = {1'b0, acc[DS-1:0]} + {1'b0, lf[i]};
               carry = acc[DS];
`endif
               d = ((lt[i] == 0) ? 1 : int'(lt[i])) + int'(carry);
               for (int c = 0; c < d; c++) begin
                  e = '{valid: 1, strobe: (c == 0), busy: 1, done: 0, idx: i, amp: la[i], off: lo[i]};
                  q.push_back(e);
               end
            end
         end
      end
      exp_pass = (n > 0) ? rep : 0;
      e = '{valid: 0, strobe: 0, busy: 0, done: 1, idx: 0, amp: '0, off: '0};
      q.push_back(e);
   endtask

   task automatic run_program(input string tag);
      build_model();
      start = 1'b1;
      foreach (q[k]) begin
         tick();
         check({tag, "/busy"},  64'(busy),      64'(q[k].busy));
         check({tag, "/valid"}, 64'(seg_valid), 64'(q[k].valid));
         check({tag, "/done"},  64'(done),      64'(q[k].done));
         if (q[k].valid) begin
            check({tag, "/strobe"}, 64'(seg_strobe), 64'(q[k].strobe));
            check({tag, "/idx"},    64'(seg_idx),    64'(q[k].idx));
            check({tag, "/amp"},    64'(seg_amp),    64'(q[k].amp));
            check({tag, "/off"},    64'(seg_offset), 64'(q[k].off));
         end
         // start while busy must be ignored
         start = q[k].busy && ($urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      check({tag, "/pass_cnt"}, 64'(pass_cnt), 64'(exp_pass));
      tick();
      check({tag, "/idle_done"}, 64'(done), 64'd0);
      check({tag, "/idle_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic set_all(input int t);
      for (int i = 0; i < NSEG; i++) begin
         la[i] = $urandom;
         lo[i] = $urandom;
         lt[i] = DS'(t);
         lf[i] = '0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      logic [DS-1:0] a_old, a0_new, a1_new;
      areset = 1'b1;
      start  = 1'b0;
      stop   = 1'b0;
      nlin   = 0;
      rep    = 1;
      set_all(1);
      tick();
      tick();
      areset = 1'b0;
      tick();
      check("reset/busy",     64'(busy),       64'd0);
      check("reset/valid",    64'(seg_valid),  64'd0);
      check("reset/strobe",   64'(seg_strobe), 64'd0);
      check("reset/done",     64'(done),       64'd0);
      check("reset/idx",      64'(seg_idx),    64'd0);
      check("reset/amp",      64'(seg_amp),    64'd0);
      check("reset/off",      64'(seg_offset), 64'd0);
      check("reset/pass_cnt", 64'(pass_cnt),   64'd0);

      // basic program
      set_all(1);
      lt[0] = 2; lt[1] = 1; lt[2] = 3;
      nlin = 3; rep = 1;
      run_program("basic");

      nlin = 0; rep = 1;
      run_program("zero");

      set_all(1);
      nlin = 20; rep = 1;
      run_program("clamp");

      set_all(1);
      nlin = 2; rep = 3;
      run_program("repeat");

`ifdef SEQ_FRAC_EN
      set_all(2);
      lf[0] = 32'h8000_0000;
      nlin = 1; rep = 4;
      run_program("frac");
`endif

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NSEG; i++) begin
            la[i] = $urandom;
            lo[i] = $urandom;
            lt[i] = DS'($urandom_range(0, 3));
            lf[i] = $urandom;
         end
         nlin = $urandom_range(0, 11);
         rep  = $urandom_range(1, 3);
         run_program($sformatf("rand%0d", r));
      end

      // infinite program, stopped after 100 full run cycles
      set_all(1);
      nlin = 2; rep = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int r = 0; r <= 100; r++) begin
         tick();
         check("inf/valid", 64'(seg_valid), 64'd1);
         check("inf/idx",   64'(seg_idx),   64'(r % 2));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("inf/done",     64'(done),      64'd1);
      check("inf/valid_off", 64'(seg_valid), 64'd0);
      check("inf/pass_cnt", 64'(pass_cnt),  64'(100 / 2));

      // stop in the second cycle of a 5-cycle segment
      set_all(5);
      nlin = 1; rep = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("stop/valid", 64'(seg_valid), 64'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop/done",  64'(done),      64'd1);
      check("stop/valid_off", 64'(seg_valid), 64'd0);
      check("stop/busy",  64'(busy),      64'd0);
      tick();
      check("stop/done_pulse", 64'(done), 64'd0);

      // start and stop together in idle
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check("race/busy", 64'(busy), 64'd0);
      tick();
      check("race/done", 64'(done), 64'd0);
      check("race/busy2", 64'(busy), 64'd0);

      // live register update
      set_all(3);
      nlin = 2; rep = 2;
      a_old  = la[0];
      a0_new = ~a_old;
      a1_new = la[1] ^ 32'h5a5a_5a5a;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("live/amp0", 64'(seg_amp), 64'(a_old));
      la[0] = a0_new;
      la[1] = a1_new;
      tick();
      check("live/amp0_hold", 64'(seg_amp), 64'(a_old));
      tick();
      tick();
      check("live/idx1", 64'(seg_idx), 64'd1);
      check("live/amp1", 64'(seg_amp), 64'(a1_new));
      tick();
      tick();
      tick();
      check("live/idx0_p2", 64'(seg_idx), 64'd0);
      check("live/amp0_p2", 64'(seg_amp), 64'(a0_new));
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
         tick();
         seen = done;
      end
      check("live/done", 64'(seen), 64'd1);

      // asynchronous reset in the middle of a segment
      set_all(4);
      nlin = 3; rep = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2 areset = 1'b1;
      #1;
      check("arst/busy",     64'(busy),       64'd0);
      check("arst/valid",    64'(seg_valid),  64'd0);
      check("arst/strobe",   64'(seg_strobe), 64'd0);
      check("arst/idx",      64'(seg_idx),    64'd0);
      check("arst/amp",      64'(seg_amp),    64'd0);
      check("arst/off",      64'(seg_offset), 64'd0);
      check("arst/pass_cnt", 64'(pass_cnt),   64'd0);
      check("arst/done",     64'(done),       64'd0);
      areset = 1'b0;
      tick();
      check("arst/done_after", 64'(done), 64'd0);
      check("arst/busy_after", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
